cache_mem_arbiter: RTL and testbench

- Shares the single 256-bit line-granular memory port between the instruction cache and the data cache. Each cache's downward-facing port connects here.
- Arbitrates requests round-robin and latches the winning request. Drives it to memory and routes the response back to the owner.
- One transaction is outstanding at a time. Sits between the two cache instances and the memory model or bus adapter.

---
 rtl/cache_mem_arbiter.sv | 135 +++++++++++++
 tb/tb_cache_mem_arbiter.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter
// Shares one line-granular memory port between the instruction cache and the
// data cache. Requests are arbitrated round-robin, the winner is latched into
// transaction registers and driven to memory, and the response is routed back
// to the owner in the same cycle mem_resp arrives. One transaction in flight.

module cache_mem_arbiter #(
    parameter int ADDR_WIDTH = 32,
    parameter int LINE_WIDTH = 256
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic [ADDR_WIDTH-1:0] i_addr,
    input  logic                  i_read,
    input  logic                  i_write,
    input  logic [LINE_WIDTH-1:0] i_wdata,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,

    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [LINE_WIDTH-1:0] mem_wdata,
    input  logic [LINE_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    localparam int OFFSET = $clog2(LINE_WIDTH / 8);

    // Clears the byte-offset bits so every memory address is line aligned.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ~ADDR_WIDTH'((1 << OFFSET) - 1);

    localparam logic [0:0] STATE_IDLE = 1'b0;
    localparam logic [0:0] STATE_BUSY = 1'b1;

    localparam logic GRANT_I = 1'b0;
    localparam logic GRANT_D = 1'b1;

    logic [0:0]            state_q;
    logic                  last_grant_q;
    logic                  owner_q;
    logic                  mem_read_q;
    logic                  mem_write_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [LINE_WIDTH-1:0] wdata_q;

    logic                  req_i;
    logic                  req_d;
    logic                  grant_valid;
    logic                  grant_sel;
    logic                  sel_write;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [LINE_WIDTH-1:0] sel_wdata;
    logic                  mem_done;

    // Round-robin choice of the next owner and the request it brings.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned (no latch).
        req_i       = i_read | i_write;
        req_d       = d_read | d_write;
        grant_valid = req_i | req_d;
        grant_sel   = GRANT_I;
        if (req_i && req_d) begin
            grant_sel = ~last_grant_q;
        end else if (req_d) begin
            grant_sel = GRANT_D;
        end
        sel_write = (grant_sel == GRANT_D) ? d_write : i_write;
        sel_addr  = (grant_sel == GRANT_D) ? d_addr  : i_addr;
        sel_wdata = (grant_sel == GRANT_D) ? d_wdata : i_wdata;
    end

    // Transaction register update: latch on grant, clear on completion.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so all registers see pre-edge values.
        if (rst) begin
            // NOTE: the address/data registers are reset too because they drive mem_* directly and must read 0.
            state_q      <= STATE_IDLE;
            last_grant_q <= GRANT_I;
            owner_q      <= GRANT_I;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else begin
            case (state_q)
                STATE_IDLE: begin
                    if (grant_valid) begin
                        state_q      <= STATE_BUSY;
                        owner_q      <= grant_sel;
                        last_grant_q <= grant_sel;
                        mem_read_q   <= ~sel_write;
                        mem_write_q  <= sel_write;
                        addr_q       <= sel_addr & LINE_MASK;
                        wdata_q      <= sel_write ? sel_wdata : '0;
                    end
                end
                STATE_BUSY: begin
                    if (mem_resp) begin
                        state_q     <= STATE_IDLE;
                        mem_read_q  <= 1'b0;
                        mem_write_q <= 1'b0;
                        addr_q      <= '0;
                        wdata_q     <= '0;
                    end
                end
                default: begin
                    state_q <= STATE_IDLE;
                end
            endcase
        end
    end

    // Memory side comes straight from registers; responses route combinationally to the owner.
    always_comb begin
        mem_read  = mem_read_q;
        mem_write = mem_write_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        mem_done  = (state_q == STATE_BUSY) && mem_resp;
        i_resp    = mem_done && (owner_q == GRANT_I);
        d_resp    = mem_done && (owner_q == GRANT_D);
        i_rdata   = (i_resp && !mem_write_q) ? mem_rdata : '0;
        d_rdata   = (d_resp && !mem_write_q) ? mem_rdata : '0;
    end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// tb_cache_mem_arbiter
// Table-driven directed vectors, a hand-written contention sequence, and a
// randomized run checked against a transaction-level reference model.

module tb_cache_mem_arbiter;

    localparam int AW = 32;
    localparam int LW = 256;

    localparam logic [LW-1:0] Z  = '0;
    localparam logic [LW-1:0] A5 = {32{8'hA5}};
    localparam logic [LW-1:0] P  = {8{32'hDEADBEEF}};
    localparam logic [LW-1:0] J  = {8{32'h0BADF00D}};
    localparam logic [LW-1:0] X1 = {8{32'h1111_0001}};
    localparam logic [LW-1:0] X2 = {8{32'h2222_0002}};
    localparam logic [LW-1:0] X3 = {8{32'h3333_0003}};
    localparam logic [LW-1:0] X4 = {8{32'h4444_0004}};
    localparam logic [LW-1:0] X5 = {8{32'h5555_0005}};
    localparam logic [LW-1:0] X6 = {8{32'h6666_0006}};

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] i_addr, d_addr, mem_addr;
    logic          i_read, i_write, d_read, d_write;
    logic [LW-1:0] i_wdata, d_wdata, i_rdata, d_rdata, mem_wdata, mem_rdata;
    logic          i_resp, d_resp, mem_read, mem_write, mem_resp;

    int tests = 0;
    int fails = 0;

    cache_mem_arbiter #(.ADDR_WIDTH(AW), .LINE_WIDTH(LW)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_write(i_write), .i_wdata(i_wdata),
        .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always #5 clk = ~clk;

    // A cache never raises read and write together.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(i_read && i_write) && !(d_read && d_write))
            else $error("illegal simultaneous read and write request");
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LW-1:0] rand_line();
        logic [LW-1:0] r;
        for (int k = 0; k < LW / 32; k++) r[k*32 +: 32] = $urandom;
        return r;
    endfunction

    typedef struct {
        logic          rst;
        logic          ir, iw;
        logic [AW-1:0] ia;
        logic          dr, dw;
        logic [AW-1:0] da;
        logic [LW-1:0] dwd;
        logic          mresp;
        logic [LW-1:0] mrd;
        logic          e_mr, e_mw;
        logic [AW-1:0] e_ma;
        logic [LW-1:0] e_mwd;
        logic          e_ir;
        logic [LW-1:0] e_ird;
        logic          e_dr;
        logic [LW-1:0] e_drd;
    } vec_t;

    vec_t vecs[$];

    task automatic v(input logic r, input logic ir, input logic iw, input logic [AW-1:0] ia,
                     input logic dr, input logic dw, input logic [AW-1:0] da, input logic [LW-1:0] dwd,
                     input logic mresp, input logic [LW-1:0] mrd,
                     input logic emr, input logic emw, input logic [AW-1:0] ema, input logic [LW-1:0] emwd,
                     input logic eir, input logic [LW-1:0] eird, input logic edr, input logic [LW-1:0] edrd);
        vec_t t;
        t.rst = r; t.ir = ir; t.iw = iw; t.ia = ia; t.dr = dr; t.dw = dw; t.da = da; t.dwd = dwd;
        t.mresp = mresp; t.mrd = mrd; t.e_mr = emr; t.e_mw = emw; t.e_ma = ema; t.e_mwd = emwd;
        t.e_ir = eir; t.e_ird = eird; t.e_dr = edr; t.e_drd = edrd;
        vecs.push_back(t);
    endtask

    // Reference model state (transaction level).
    logic          c_act[2];
    logic          c_wr[2];
    logic [AW-1:0] c_addr[2];
    logic [LW-1:0] c_wdata[2];
    logic          m_valid;
    int            m_owner;
    logic          m_write;
    logic [AW-1:0] m_addr;
    logic [LW-1:0] m_wdata;
    int            m_last;
    int            m_cnt;

    initial begin
        rst = 1'b1;
        i_addr = '0; i_read = 1'b0; i_write = 1'b0; i_wdata = J;
        d_addr = '0; d_read = 1'b0; d_write = 1'b0; d_wdata = J;
        mem_rdata = '0; mem_resp = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        // ---------------- directed table ----------------
        // reset state
        v(1, 0,0,32'h0,        0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        // single I read, response after 3 busy cycles
        v(0, 1,0,32'h1234,     0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        v(0, 1,0,32'h1234,     0,0,32'h0,        J, 0,Z,  1,0,32'h1220,     Z, 0,Z,  0,Z);
        v(0, 1,0,32'h1234,     0,0,32'h0,        J, 0,Z,  1,0,32'h1220,     Z, 0,Z,  0,Z);
        v(0, 1,0,32'h1234,     0,0,32'h0,        J, 0,Z,  1,0,32'h1220,     Z, 0,Z,  0,Z);
        v(0, 1,0,32'h1234,     0,0,32'h0,        J, 1,A5, 1,0,32'h1220,     Z, 1,A5, 0,Z);
        v(0, 0,0,32'h0,        0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        // D writeback
        v(0, 0,0,32'h0,        0,1,32'h8000_0040,P, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        v(0, 0,0,32'h0,        0,1,32'h8000_0040,P, 0,Z,  0,1,32'h8000_0040,P, 0,Z,  0,Z);
        v(0, 0,0,32'h0,        0,1,32'h8000_0040,P, 1,A5, 0,1,32'h8000_0040,P, 0,Z,  1,Z);
        // mem_resp while idle is ignored
        v(0, 0,0,32'h0,        0,0,32'h0,        J, 1,A5, 0,0,32'h0,        Z, 0,Z,  0,Z);
        // simultaneous after reset: D first, then I
        v(1, 0,0,32'h0,        0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        v(0, 1,0,32'h100,      1,0,32'h200,      J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        v(0, 1,0,32'h100,      1,0,32'h200,      J, 0,Z,  1,0,32'h200,      Z, 0,Z,  0,Z);
        v(0, 1,0,32'h100,      1,0,32'h200,      J, 1,X1, 1,0,32'h200,      Z, 0,Z,  1,X1);
        v(0, 1,0,32'h100,      0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        v(0, 1,0,32'h100,      0,0,32'h0,        J, 0,Z,  1,0,32'h100,      Z, 0,Z,  0,Z);
        v(0, 1,0,32'h100,      0,0,32'h0,        J, 1,X2, 1,0,32'h100,      Z, 1,X2, 0,Z);
        v(0, 0,0,32'h0,        0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        // upstream changes while busy are ignored
        v(0, 1,0,32'h3000,     0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        v(0, 1,0,32'h3000,     0,0,32'h0,        J, 0,Z,  1,0,32'h3000,     Z, 0,Z,  0,Z);
        v(0, 1,0,32'h5555,     1,0,32'h7000,     J, 0,Z,  1,0,32'h3000,     Z, 0,Z,  0,Z);
        v(0, 1,0,32'h5555,     1,0,32'h7000,     J, 1,X3, 1,0,32'h3000,     Z, 1,X3, 0,Z);
        v(0, 0,0,32'h0,        1,0,32'h7000,     J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        v(0, 0,0,32'h0,        1,0,32'h7000,     J, 0,Z,  1,0,32'h7000,     Z, 0,Z,  0,Z);
        v(0, 0,0,32'h0,        1,0,32'h7000,     J, 1,X4, 1,0,32'h7000,     Z, 0,Z,  1,X4);
        v(0, 0,0,32'h0,        0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        // reset mid-transaction, then a fresh read
        v(0, 1,0,32'h40,       0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        v(1, 1,0,32'h40,       0,0,32'h0,        J, 0,Z,  1,0,32'h40,       Z, 0,Z,  0,Z);
        v(0, 0,0,32'h0,        0,0,32'h0,        J, 1,X5, 0,0,32'h0,        Z, 0,Z,  0,Z);
        v(0, 1,0,32'h84,       0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);
        v(0, 1,0,32'h84,       0,0,32'h0,        J, 0,Z,  1,0,32'h80,       Z, 0,Z,  0,Z);
        v(0, 1,0,32'h84,       0,0,32'h0,        J, 1,X6, 1,0,32'h80,       Z, 1,X6, 0,Z);
        v(0, 0,0,32'h0,        0,0,32'h0,        J, 0,Z,  0,0,32'h0,        Z, 0,Z,  0,Z);

        for (int n = 0; n < vecs.size(); n++) begin
            rst = vecs[n].rst;
            i_read = vecs[n].ir; i_write = vecs[n].iw; i_addr = vecs[n].ia; i_wdata = J;
            d_read = vecs[n].dr; d_write = vecs[n].dw; d_addr = vecs[n].da; d_wdata = vecs[n].dwd;
            mem_resp = vecs[n].mresp; mem_rdata = vecs[n].mrd;
            #1;
            check($sformatf("vec%0d mem_read", n),  LW'(mem_read),  LW'(vecs[n].e_mr));
            check($sformatf("vec%0d mem_write", n), LW'(mem_write), LW'(vecs[n].e_mw));
            check($sformatf("vec%0d mem_addr", n),  LW'(mem_addr),  LW'(vecs[n].e_ma));
            check($sformatf("vec%0d mem_wdata", n), mem_wdata,      vecs[n].e_mwd);
            check($sformatf("vec%0d i_resp", n),    LW'(i_resp),    LW'(vecs[n].e_ir));
            check($sformatf("vec%0d i_rdata", n),   i_rdata,        vecs[n].e_ird);
            check($sformatf("vec%0d d_resp", n),    LW'(d_resp),    LW'(vecs[n].e_dr));
            check($sformatf("vec%0d d_rdata", n),   d_rdata,        vecs[n].e_drd);
            step();
        end

        // ---------------- continuous contention ----------------
        rst = 1'b1; i_read = 1'b0; d_read = 1'b0; mem_resp = 1'b0;
        step();
        rst = 1'b0;
        i_addr = 32'h1000; d_addr = 32'h2000; i_read = 1'b1; d_read = 1'b1;
        for (int t = 0; t < 8; t++) begin
            logic          own_d;
            logic [LW-1:0] line;
            int            lat;
            own_d = (t % 2 == 0);
            #1;
            check($sformatf("cont%0d idle mem_read", t), LW'(mem_read), LW'(1'b0));
            step();
            #1;
            check($sformatf("cont%0d mem_read", t), LW'(mem_read), LW'(1'b1));
            check($sformatf("cont%0d order addr", t), LW'(mem_addr), LW'(own_d ? d_addr : i_addr));
            lat = $urandom_range(0, 2);
            repeat (lat) step();
            line = rand_line();
            mem_resp = 1'b1; mem_rdata = line;
            #1;
            check($sformatf("cont%0d i_resp", t), LW'(i_resp), LW'(!own_d));
            check($sformatf("cont%0d d_resp", t), LW'(d_resp), LW'(own_d));
            check($sformatf("cont%0d rdata", t), own_d ? d_rdata : i_rdata, line);
            step();
            mem_resp = 1'b0;
            if (own_d) d_addr = d_addr + 32'h20;
            else       i_addr = i_addr + 32'h20;
        end
        i_read = 1'b0; d_read = 1'b0;

        // ---------------- randomized run vs. model ----------------
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int p = 0; p < 2; p++) begin
            c_act[p] = 1'b0; c_wr[p] = 1'b0; c_addr[p] = '0; c_wdata[p] = '0;
        end
        m_valid = 1'b0; m_owner = 0; m_write = 1'b0; m_addr = '0; m_wdata = '0;
        m_last = 0; m_cnt = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            logic          done;
            logic [LW-1:0] rd;
            for (int p = 0; p < 2; p++) begin
                if (!c_act[p] && $urandom_range(0, 2) == 0) begin
                    c_act[p]   = 1'b1;
                    c_wr[p]    = ($urandom_range(0, 3) == 0);
                    c_addr[p]  = $urandom;
                    c_wdata[p] = rand_line();
                end
            end
            i_read  = c_act[0] && !c_wr[0]; i_write = c_act[0] && c_wr[0];
            i_addr  = c_act[0] ? c_addr[0] : AW'($urandom); i_wdata = c_wdata[0];
            d_read  = c_act[1] && !c_wr[1]; d_write = c_act[1] && c_wr[1];
            d_addr  = c_act[1] ? c_addr[1] : AW'($urandom); d_wdata = c_wdata[1];
            rd = rand_line();
            mem_rdata = rd;
            mem_resp  = m_valid ? (m_cnt == 0) : ($urandom_range(0, 7) == 0);
            #1;
            done = m_valid && mem_resp;
            check("rand mem_read",  LW'(mem_read),  LW'(m_valid && !m_write));
            check("rand mem_write", LW'(mem_write), LW'(m_valid && m_write));
            check("rand mem_addr",  LW'(mem_addr),  LW'(m_valid ? m_addr : '0));
            check("rand mem_wdata", mem_wdata, (m_valid && m_write) ? m_wdata : Z);
            check("rand i_resp",    LW'(i_resp),    LW'(done && m_owner == 0));
            check("rand d_resp",    LW'(d_resp),    LW'(done && m_owner == 1));
            check("rand i_rdata",   i_rdata, (done && m_owner == 0 && !m_write) ? rd : Z);
            check("rand d_rdata",   d_rdata, (done && m_owner == 1 && !m_write) ? rd : Z);
            if (m_valid) begin
                if (mem_resp) begin
                    m_valid = 1'b0;
                    c_act[m_owner] = 1'b0;
                end else begin
                    m_cnt--;
                end
            end else if (c_act[0] || c_act[1]) begin
                if (c_act[0] && c_act[1]) m_owner = 1 - m_last;
                else                      m_owner = c_act[1] ? 1 : 0;
                m_valid = 1'b1;
                m_write = c_wr[m_owner];
                m_addr  = c_addr[m_owner] & ~32'h1F;
                m_wdata = c_wr[m_owner] ? c_wdata[m_owner] : Z;
                m_last  = m_owner;
                m_cnt   = $urandom_range(0, 3);
            end
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
